// File: rtl/monitor_frame_rx.sv
// Frame-level UART monitor: hunts for a start byte after an idle gap, collects a
// fixed-length frame into a shadow buffer and commits it atomically to the LED display buffer.
module monitor_frame_rx #(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned FRAME_BYTES  = 25,
  parameter logic [7:0]  START_BYTE   = 8'h0F,
  parameter int unsigned GAP_CYCLES   = 1000,
  parameter int unsigned SEL_BITS     = 5
) (
  input  logic                    clk,
  input  logic                    sw_0,
  input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
  input  logic                    uart_rx_valid,
  input  logic                    uart_rx_break,
  input  logic [SEL_BITS-1:0]     sel,
  input  logic                    mode,
  input  logic                    clr_err,
  output logic [7:0]              led,
  output logic                    frame_valid,
  output logic [7:0]              frame_cnt,
  output logic                    err_short,
  output logic                    err_break
);

  localparam int unsigned IDX_W = (FRAME_BYTES > 2) ? $clog2(FRAME_BYTES) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [GAP_W-1:0]        gap_cnt;
  logic [PAYLOAD_BITS-1:0] shadow  [FRAME_BYTES];
  logic [PAYLOAD_BITS-1:0] display [FRAME_BYTES];

  logic       gap_seen_c;
  logic       start_ok_c;
  logic       set_short_c;
  logic       sel_in_range_c;
  logic [7:0] led_c;

  assign gap_seen_c     = (gap_cnt == GAP_MAX);
  assign start_ok_c     = uart_rx_valid && gap_seen_c && (uart_rx_data[7:0] == START_BYTE);
  assign set_short_c    = !uart_rx_break && (state == ST_RECV) && !uart_rx_valid && gap_seen_c;
  assign sel_in_range_c = (32'(sel) < FRAME_BYTES);

  // LED source: selected display byte or status word built from current registers
  always_comb begin
    led_c = 8'h00;
    if (mode) begin
      led_c = {err_break, err_short, (state == ST_RECV), 1'b0, frame_cnt[3:0]};
    end else if (sel_in_range_c) begin
      led_c = display[IDX_W'(sel)][7:0];
    end
  end

  // Frame collection, commit, error flags and registered LED drive
  always_ff @(posedge clk or negedge sw_0) begin
    if (!sw_0) begin
      state       <= ST_HUNT;
      idx         <= '0;
      gap_cnt     <= GAP_MAX;
      led         <= 8'hF0;
      frame_valid <= 1'b0;
      frame_cnt   <= 8'h00;
      err_short   <= 1'b0;
      err_break   <= 1'b0;
      for (int i = 0; i < int'(FRAME_BYTES); i++) begin
        shadow[i]  <= '0;
        display[i] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      led         <= led_c;
      err_short   <= set_short_c | (err_short & ~clr_err);
      err_break   <= uart_rx_break | (err_break & ~clr_err);

      if (uart_rx_valid) begin
        gap_cnt <= '0;
      end else if (!gap_seen_c) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end

      // Commit still happens when a break lands in the commit cycle
      if (state == ST_COMMIT) begin
        for (int i = 0; i < int'(FRAME_BYTES); i++) begin
          display[i] <= shadow[i];
        end
        frame_valid <= 1'b1;
        frame_cnt   <= frame_cnt + 8'd1;
      end

      if (uart_rx_break) begin
        state <= ST_HUNT;
        idx   <= '0;
      end else begin
        case (state)
          ST_RECV: begin
            if (uart_rx_valid) begin
              shadow[idx] <= uart_rx_data;
              if (idx == LAST_IDX) begin
                state <= ST_COMMIT;
                idx   <= '0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else if (gap_seen_c) begin
              state <= ST_HUNT;
              idx   <= '0;
            end
          end
          default: begin
            // HUNT and the single COMMIT cycle both accept a new start byte
            state <= ST_HUNT;
            idx   <= '0;
            if (start_ok_c) begin
              shadow[0] <= uart_rx_data;
              idx       <= IDX_W'(1);
              state     <= ST_RECV;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_monitor_frame_rx.sv
// Bench for monitor_frame_rx: directed scenarios plus randomized frames, checked each
// cycle against a queue-based frame model, with literal expectations at key points.
module tb_monitor_frame_rx;

  localparam int unsigned GAP = 20;
  localparam int unsigned FB  = 25;

  logic       clk = 1'b0;
  logic       sw_0 = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rx_valid = 1'b0;
  logic       uart_rx_break = 1'b0;
  logic [4:0] sel = 5'd0;
  logic       mode = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] led;
  logic       frame_valid;
  logic [7:0] frame_cnt;
  logic       err_short;
  logic       err_break;

  monitor_frame_rx #(
    .PAYLOAD_BITS(8),
    .FRAME_BYTES (FB),
    .START_BYTE  (8'h0F),
    .GAP_CYCLES  (GAP),
    .SEL_BITS    (5)
  ) dut (
    .clk          (clk),
    .sw_0         (sw_0),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_break(uart_rx_break),
    .sel          (sel),
    .mode         (mode),
    .clr_err      (clr_err),
    .led          (led),
    .frame_valid  (frame_valid),
    .frame_cnt    (frame_cnt),
    .err_short    (err_short),
    .err_break    (err_break)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int fv_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a frame is a queue of bytes being collected; a full queue is committed one cycle later
  logic [7:0] m_led;
  logic       m_fv;
  logic [7:0] m_cnt;
  logic       m_es, m_eb;
  logic [7:0] m_disp [FB];
  logic [7:0] m_buf  [FB];
  logic [7:0] m_q [$];
  bit         m_pending;
  int         m_idle;
  bit         m_gap, m_set_s;
  logic [7:0] m_nled;

  always @(posedge clk or negedge sw_0) begin
    if (!sw_0) begin
      m_led = 8'hF0; m_fv = 1'b0; m_cnt = 8'h00; m_es = 1'b0; m_eb = 1'b0;
      foreach (m_disp[i]) begin m_disp[i] = 8'h00; m_buf[i] = 8'h00; end
      m_q.delete();
      m_pending = 1'b0;
      m_idle = GAP;
    end else begin
      m_gap = (m_idle >= GAP);
      if (mode) m_nled = {m_eb, m_es, (m_q.size() != 0), 1'b0, m_cnt[3:0]};
      else      m_nled = (sel < FB) ? m_disp[sel] : 8'h00;
      m_fv = 1'b0;
      m_set_s = 1'b0;
      if (m_pending) begin
        foreach (m_disp[i]) m_disp[i] = m_buf[i];
        m_fv = 1'b1;
        m_cnt = m_cnt + 8'd1;
        m_pending = 1'b0;
      end
      if (uart_rx_break) begin
        m_q.delete();
      end else if (m_q.size() != 0) begin
        if (uart_rx_valid) begin
          m_q.push_back(uart_rx_data);
          if (m_q.size() == FB) begin
            foreach (m_buf[i]) m_buf[i] = m_q[i];
            m_pending = 1'b1;
            m_q.delete();
          end
        end else if (m_gap) begin
          m_set_s = 1'b1;
          m_q.delete();
        end
      end else if (uart_rx_valid && m_gap && uart_rx_data == 8'h0F) begin
        m_q.push_back(uart_rx_data);
      end
      m_es = m_set_s | (m_es & !clr_err);
      m_eb = uart_rx_break | (m_eb & !clr_err);
      m_idle = uart_rx_valid ? 0 : ((m_idle < GAP) ? m_idle + 1 : GAP);
      m_led = m_nled;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("led", 32'(led), 32'(m_led));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      check("err_short", 32'(err_short), 32'(m_es));
      check("err_break", 32'(err_break), 32'(m_eb));
      if (frame_valid === 1'b1) fv_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int spacing, input bit with_brk);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    uart_rx_break = with_brk;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    uart_rx_break = 1'b0;
    if (spacing > 1) tick(spacing - 1);
  endtask

  task automatic send_frame(input int spacing);
    send_byte(8'h0F, spacing, 1'b0);
    for (int i = 1; i < int'(FB); i++) send_byte(8'(i), spacing, 1'b0);
  endtask

  initial begin
    int k;
    int kind;
    int n;
    int sp;

    // Reset behaviour and first frame
    tick(2);
    chk_en = 1'b1;
    check("reset_led", 32'(led), 32'h0F0);
    check("reset_cnt", 32'(frame_cnt), 32'h0);
    sw_0 = 1'b1;
    tick(1);
    check("led_after_first_clk", 32'(led), 32'h00);
    send_frame(10);
    check("first_frame_cnt", 32'(frame_cnt), 32'd1);
    sel = 5'd5;
    tick(1);
    check("first_frame_sel5", 32'(led), 32'h05);

    // Start byte without gap is rejected; after a gap a frame is accepted
    send_byte(8'h0F, 1, 1'b0);
    tick(GAP + 2);
    check("no_gap_reject_cnt", 32'(frame_cnt), 32'd1);
    send_frame(10);
    check("second_frame_cnt", 32'(frame_cnt), 32'd2);

    // Short frame: 0x0F plus 10 bytes then idle
    tick(GAP + 1);
    send_byte(8'h0F, 3, 1'b0);
    for (int i = 1; i < 10; i++) send_byte(8'(8'h40 + i), 3, 1'b0);
    send_byte(8'h4A, 1, 1'b0);
    k = 0;
    while (k < 3 * int'(GAP) && err_short !== 1'b1) begin
      tick(1);
      k++;
    end
    check("short_latency", 32'(k), 32'(GAP + 1));
    check("short_flag", 32'(err_short), 32'd1);
    check("short_display_kept", 32'(led), 32'h05);
    mode = 1'b1;
    tick(1);
    check("status_after_short", 32'(led), 32'h42);
    mode = 1'b0;

    // Break together with a valid byte mid-frame
    tick(GAP + 1);
    send_byte(8'h0F, 3, 1'b0);
    for (int i = 1; i <= 5; i++) send_byte(8'(8'h60 + i), 3, 1'b0);
    send_byte(8'h77, 1, 1'b1);
    check("break_flag", 32'(err_break), 32'd1);
    mode = 1'b1;
    tick(1);
    check("status_after_break", 32'(led), 32'hC2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_short", 32'(err_short), 32'd0);
    check("clr_break", 32'(err_break), 32'd0);
    check("break_no_commit", 32'(frame_cnt), 32'd2);
    mode = 1'b0;

    // Out-of-range select
    sel = 5'd31;
    tick(1);
    check("sel31_led", 32'(led), 32'h00);

    // Randomized traffic
    tick(GAP + 1);
    for (int it = 0; it < 60; it++) begin
      sel  = 5'($urandom_range(0, 31));
      mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
      end
      kind = $urandom_range(0, 4);
      sp   = $urandom_range(1, 5);
      n    = $urandom_range(1, FB - 2);
      case (kind)
        0, 1: begin
          send_byte(8'h0F, sp, 1'b0);
          for (int i = 1; i < int'(FB); i++) send_byte(8'($urandom), sp, 1'b0);
        end
        2: begin
          send_byte(8'h0F, sp, 1'b0);
          for (int i = 0; i < n; i++) send_byte(8'($urandom), sp, 1'b0);
        end
        3: begin
          send_byte(8'h0F, sp, 1'b0);
          for (int i = 0; i < n; i++) send_byte(8'($urandom), sp, 1'b0);
          send_byte(8'($urandom), 1, 1'b1);
        end
        default: begin
          for (int i = 0; i < 4; i++) send_byte(8'($urandom), $urandom_range(1, 30), 1'b0);
        end
      endcase
      tick($urandom_range(0, GAP + 5));
    end

    // Counter wrap after 256 frames from reset
    @(negedge clk);
    #2 sw_0 = 1'b0;
    @(negedge clk);
    sw_0 = 1'b1;
    sel = 5'd7;
    mode = 1'b0;
    fv_seen = 0;
    repeat (256) begin
      send_frame(2);
      tick(GAP + 1);
    end
    check("wrap_cnt", 32'(frame_cnt), 32'd0);
    check("wrap_pulses", 32'(fv_seen), 32'd256);
    check("wrap_led_sel7", 32'(led), 32'h07);

    // Reset in the middle of a frame
    tick(GAP + 1);
    send_byte(8'h0F, 3, 1'b0);
    for (int i = 1; i <= 11; i++) send_byte(8'(8'h80 + i), 3, 1'b0);
    #2 sw_0 = 1'b0;
    #1;
    check("midreset_led", 32'(led), 32'h0F0);
    check("midreset_cnt", 32'(frame_cnt), 32'd0);
    check("midreset_fv", 32'(frame_valid), 32'd0);
    check("midreset_es", 32'(err_short), 32'd0);
    check("midreset_eb", 32'(err_break), 32'd0);
    @(negedge clk);
    tick(1);
    sw_0 = 1'b1;
    send_frame(3);
    check("post_reset_cnt", 32'(frame_cnt), 32'd1);
    check("post_reset_led", 32'(led), 32'h07);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
